// File: rtl/irq_trap_ctrl.sv
// Core-side interrupt responder: gates arbiter requests, traps at an instruction boundary, returns on mret.
// Optional nested-trap context stack enabled with `define IRQ_NEST_EN.
module irq_trap_ctrl #(
   parameter int             XLEN       = 32,
   parameter int             NEST_DEPTH = 4,
   parameter logic [4:0]     CAUSE_EXT  = 5'h0B
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            irq_i,
   input  logic [4:0]      irq_cause_i,
   input  logic [XLEN-1:0] irq_extra_i,
   output logic            irq_ack_o,
   output logic            irq_complete_o,
   input  logic            mstatus_mie_i,
   input  logic [2:0]      mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            boundary_i,
   input  logic            mret_i,
   output logic            flush_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            csr_save_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtval_o,
   output logic            mie_clr_o,
   output logic            mie_restore_o,
   output logic            in_handler_o
);

   localparam int DW = $clog2(NEST_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_PEND, S_TAKE, S_HANDLER, S_RETURN} state_t;

   typedef struct packed {
      logic [XLEN-1:0] mepc;
      logic [XLEN-1:0] mcause;
      logic [XLEN-1:0] mtval;
   } ctx_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   depth_q;
   logic            src_en, enabled, nest_take;
   logic [XLEN-1:0] base, vec_pc;

   always_comb begin
      case (irq_cause_i)
         5'd3:    src_en = mie_i[0];
         5'd7:    src_en = mie_i[1];
         5'd11:   src_en = mie_i[2];
         default: src_en = 1'b0;
      endcase
   end

   assign enabled = irq_i & mstatus_mie_i & src_en;
   assign base    = {mtvec_i[XLEN-1:2], 2'b00};
   assign vec_pc  = (mtvec_i[1:0] == 2'b01) ? base + (XLEN'(irq_cause_i) << 2) : base;

`ifdef IRQ_NEST_EN
   // A full stack simply holds further interrupts off until a level unwinds.
   assign nest_take = enabled & boundary_i & (depth_q != DW'(NEST_DEPTH));
`else
   assign nest_take = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      irq_ack_o      = 1'b0;
      irq_complete_o = 1'b0;
      flush_o        = 1'b0;
      redirect_o     = 1'b0;
      csr_save_o     = 1'b0;
      mie_clr_o      = 1'b0;
      mie_restore_o  = 1'b0;
      case (state_q)
         S_IDLE: if (enabled) state_d = S_PEND;
         S_PEND: begin
            if (!enabled)       state_d = S_IDLE;
            else if (boundary_i) state_d = S_TAKE;
         end
         S_TAKE: begin
            flush_o    = 1'b1;
            redirect_o = 1'b1;
            csr_save_o = 1'b1;
            irq_ack_o  = 1'b1;
            mie_clr_o  = 1'b1;
            state_d    = S_HANDLER;
         end
         S_HANDLER: begin
            if (mret_i)         state_d = S_RETURN;
            else if (nest_take) state_d = S_TAKE;
         end
         S_RETURN: begin
            flush_o        = 1'b1;
            redirect_o     = 1'b1;
            mie_restore_o  = 1'b1;
            irq_complete_o = (mcause_o[4:0] == CAUSE_EXT);
            state_d        = (depth_q > DW'(1)) ? S_HANDLER : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Depth counts live handler levels; without nesting it only ever reaches 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  depth_q <= '0;
      else if (state_q == S_TAKE)   depth_q <= depth_q + DW'(1);
      else if (state_q == S_RETURN) depth_q <= depth_q - DW'(1);
   end

   assign in_handler_o = (depth_q != '0);

`ifdef IRQ_NEST_EN
   ctx_t stack_q [NEST_DEPTH];

   always_ff @(posedge clk) begin
      if (state_d == S_TAKE && depth_q != '0)
         stack_q[DW'(depth_q - DW'(1))] <= '{mepc: mepc_o, mcause: mcause_o, mtval: mtval_o};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc_o        <= '0;
         mcause_o      <= '0;
         mtval_o       <= '0;
         redirect_pc_o <= '0;
      end else begin
         // Cause, extra and PC are captured in the cycle the trap is committed.
         if (state_d == S_TAKE) begin
            mepc_o        <= pc_i;
            mcause_o      <= {1'b1, {(XLEN-6){1'b0}}, irq_cause_i};
            mtval_o       <= (irq_cause_i == CAUSE_EXT) ? irq_extra_i : '0;
            redirect_pc_o <= vec_pc;
         end else if (state_q == S_HANDLER && mret_i) begin
            redirect_pc_o <= mepc_o;
         end
`ifdef IRQ_NEST_EN
         if (state_q == S_RETURN && depth_q > DW'(1))
            {mepc_o, mcause_o, mtval_o} <= stack_q[DW'(depth_q - DW'(2))];
`endif
      end
   end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed test-plan cases plus a random run against a phase model.
module tb_irq_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq, ack, complete, mst, boundary, mret;
   logic        flush, redirect, csr_save, mie_clr, mie_restore, in_handler;
   logic [4:0]  cause;
   logic [2:0]  mie;
   logic [31:0] extra, mtvec, pc, redirect_pc, mepc, mcause, mtval;

   always #5 clk = ~clk;

   irq_trap_ctrl dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_cause_i(cause), .irq_extra_i(extra),
      .irq_ack_o(ack), .irq_complete_o(complete), .mstatus_mie_i(mst), .mie_i(mie),
      .mtvec_i(mtvec), .pc_i(pc), .boundary_i(boundary), .mret_i(mret),
      .flush_o(flush), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
      .csr_save_o(csr_save), .mepc_o(mepc), .mcause_o(mcause), .mtval_o(mtval),
      .mie_clr_o(mie_clr), .mie_restore_o(mie_restore), .in_handler_o(in_handler)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Phase model: 0 idle, 1 waiting for boundary, 2 trap cycle, 3 handler, 4 return cycle.
   int          m_ph;
   logic [31:0] m_mepc, m_mcause, m_mtval, m_rpc;

   function automatic logic en_f(logic i, logic g, logic [2:0] e, logic [4:0] c);
      return i && g && ((c == 5'd3 && e[0]) || (c == 5'd7 && e[1]) || (c == 5'd11 && e[2]));
   endfunction

   function automatic logic [31:0] vec_f(logic [31:0] tv, logic [4:0] c);
      logic [31:0] b;
      b = tv & 32'hFFFF_FFFC;
      return (tv[1:0] == 2'b01) ? b + 32'(c) * 32'd4 : b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_mepc <= '0; m_mcause <= '0; m_mtval <= '0; m_rpc <= '0;
      end else begin
         case (m_ph)
            0: if (en_f(irq, mst, mie, cause)) m_ph <= 1;
            1: if (!en_f(irq, mst, mie, cause)) m_ph <= 0;
               else if (boundary) begin
                  m_ph     <= 2;
                  m_mepc   <= pc;
                  m_mcause <= 32'h8000_0000 + 32'(cause);
                  m_mtval  <= (cause == 5'd11) ? extra : 32'd0;
                  m_rpc    <= vec_f(mtvec, cause);
               end
            2: m_ph <= 3;
            3: if (mret) begin m_ph <= 4; m_rpc <= m_mepc; end
            default: m_ph <= 0;
         endcase
      end
   end

   logic       cmp_on = 1'b0;
   logic [7:0] exp_p, act_p;

   always @(negedge clk) begin
      if (cmp_on) begin
         exp_p = {m_ph == 2, m_ph == 4 && m_mcause[4:0] == 5'd11, m_ph == 2 || m_ph == 4,
                  m_ph == 2 || m_ph == 4, m_ph == 2, m_ph == 2, m_ph == 4, m_ph == 3 || m_ph == 4};
         act_p = {ack, complete, flush, redirect, csr_save, mie_clr, mie_restore, in_handler};
         chk("pulses", 128'(act_p), 128'(exp_p));
         chk("csrs", 128'({mepc, mcause, mtval}), 128'({m_mepc, m_mcause, m_mtval}));
         if (m_ph == 2 || m_ph == 4) chk("redirect_pc", 128'(redirect_pc), 128'(m_rpc));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_ack(output int k);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack) begin k = i; break; end
      end
   endtask

   int k, cnt, cnt2;
   logic [4:0] causes [5] = '{5'd3, 5'd7, 5'd11, 5'd5, 5'd11};

   initial begin
      rst_n = 1'b0; irq = 0; cause = 5'd7; extra = '0; mst = 1; mie = 3'b111;
      mtvec = '0; pc = '0; boundary = 1; mret = 0;
      repeat (3) tick();
      chk("rst_state", 128'({ack, complete, flush, in_handler, redirect_pc, mepc, mcause, mtval}), 128'(0));
      rst_n = 1'b1;
      cmp_on = 1'b1;
      tick();

      // 1: vectored timer trap and plain return
      mtvec = 32'h8000_0001; cause = 5'd7; pc = 32'h100; irq = 1;
      wait_ack(k);
      chk("t1_latency", 128'(k), 128'(2));
      chk("t1_rpc", 128'(redirect_pc), 128'(32'h8000_001C));
      chk("t1_csrs", 128'({mepc, mcause, mtval}), 128'({32'h100, 32'h8000_0007, 32'h0}));
      irq = 0; tick();
      chk("t1_in_handler", 128'(in_handler), 128'(1));
      mret = 1; tick(); mret = 0;
      chk("t1_ret", 128'({redirect, complete, redirect_pc}), 128'({1'b1, 1'b0, 32'h100}));
      tick();
      chk("t1_idle", 128'(in_handler), 128'(0));

      // 2: external interrupt, direct mode, complete on return
      mtvec = 32'h8000_0000; cause = 5'd11; extra = 32'd5; pc = 32'h340; irq = 1;
      wait_ack(k);
      chk("t2_rpc", 128'(redirect_pc), 128'(32'h8000_0000));
      chk("t2_mtval", 128'({mcause, mtval}), 128'({32'h8000_000B, 32'd5}));
      irq = 0; tick();
      mret = 1; cnt = 0;
      for (int i = 0; i < 5; i++) begin tick(); mret = 0; if (complete) cnt++; end
      chk("t2_complete_once", 128'(cnt), 128'(1));

      // 3: masked sources never trap
      cnt = 0; cause = 5'd7; mie = 3'b101; irq = 1;
      for (int i = 0; i < 8; i++) begin tick(); if (ack || in_handler) cnt++; end
      mie = 3'b111; mst = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (ack || in_handler) cnt++; end
      mst = 1; cause = 5'd5;
      for (int i = 0; i < 8; i++) begin tick(); if (ack || in_handler) cnt++; end
      chk("t3_no_trap", 128'(cnt), 128'(0));
      irq = 0; tick();

      // 4: request withdrawn before a boundary, then held until one arrives
      cnt = 0; boundary = 0; cause = 5'd3; irq = 1;
      for (int i = 1; i <= 6; i++) begin
         if (i == 4) irq = 0;
         tick();
         if (ack || flush) cnt++;
      end
      chk("t4_withdrawn", 128'(cnt), 128'(0));
      irq = 1;
      for (int i = 0; i < 6; i++) begin tick(); if (ack || flush) cnt++; end
      chk("t4_held_no_boundary", 128'(cnt), 128'(0));
      boundary = 1; pc = 32'h0000_0777;
      wait_ack(k);
      chk("t4_latency", 128'(k), 128'(1));
      chk("t4_mepc", 128'(mepc), 128'(32'h777));
      irq = 0; tick(); mret = 1; tick(); mret = 0; tick();

      // 5: reset inside a handler
      cause = 5'd11; extra = 32'hAB; irq = 1;
      wait_ack(k);
      irq = 0; tick();
      #2 rst_n = 1'b0;
      #1 chk("t5_async_clear", 128'({in_handler, complete}), 128'(0));
      tick();
      #2 rst_n = 1'b1;
      mret = 1; cnt = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (redirect || complete || mie_restore) cnt++; end
      mret = 0;
      chk("t5_mret_ignored", 128'(cnt), 128'(0));

      // random run, checked every cycle by the model
      cnt2 = 0;
      for (int i = 0; i < 3000; i++) begin
         irq      = ($urandom_range(0, 3) != 0);
         cause    = causes[$urandom_range(0, 4)];
         extra    = $urandom;
         mie      = 3'($urandom);
         mst      = ($urandom_range(0, 7) != 0);
         mtvec    = $urandom;
         pc       = $urandom;
         boundary = ($urandom_range(0, 2) == 0);
         mret     = ($urandom_range(0, 5) == 0);
         tick();
         if (ack) cnt2++;
      end
      chk("rand_traps_seen", 128'(cnt2 > 20), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
